axis_seq_checker: RTL

- Synthesizable AXI-Stream sink; the receiving end of an incrementing-sequence stream produced by an upstream source or FIFO chain.
- Accepts a programmed number of beats and checks each against an expected counter.
- Reports beat count, error count, sticky error and the first mismatch.
- Used in on-chip loopback and self-test of the stream FIFOs. Replaces behavioural recv/compare loops with hardware.

---
 rtl/axis_chk_pkg.sv | 19 +
 rtl/lfsr16.sv | 38 +++
 rtl/axis_seq_checker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream sequence checker: FSM encodings and
// the LFSR seed/taps behind the optional AXIS_CHK_STALL_EN backpressure mode.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Fibonacci step, taps 16,14,13,11: feedback enters at bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload to the seed and a step enable.
module lfsr16
    import axis_chk_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_reload,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Next-state selection: reload wins over stepping
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (i_reload) begin
            w_lfsr_nxt = LFSR_SEED;
        end else if (i_en) begin
            w_lfsr_nxt = lfsr_step(r_lfsr);
        end else begin
            w_lfsr_nxt = r_lfsr;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks a programmed number of beats against an
// incrementing counter. Define AXIS_CHK_STALL_EN for LFSR-driven backpressure.
module axis_seq_checker
    import axis_chk_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] beats,
    output logic [CNT_W-1:0] errors,
    output logic             err_sticky,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_got
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    chk_state_e       r_state;
    chk_state_e       w_state_nxt;
    logic             r_tready;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_length;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_errors;
    logic             r_sticky;
    logic [WIDTH-1:0] r_err_exp;
    logic [WIDTH-1:0] r_err_got;
    logic [WIDTH-1:0] r_expected;

    logic             w_accept;
    logic             w_last;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_beats_inc;
    logic             w_tready_nxt;

    assign w_accept    = s_axis_tvalid && r_tready;
    assign w_beats_inc = r_beats + CNT_ONE;
    assign w_last      = w_accept && (w_beats_inc == r_length);
    assign w_mismatch  = (s_axis_tdata != r_expected);

    // Next FSM state; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (length != CNT_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef AXIS_CHK_STALL_EN
    logic [15:0] w_lfsr;
    logic        w_lfsr_en;
    logic        w_lfsr_reload;
    logic        w_lfsr_bit0_nxt;

    assign w_lfsr_en     = (r_state == ST_RUN);
    assign w_lfsr_reload = (r_state == ST_IDLE) && start;

    lfsr16 u_lfsr (
        .i_clk    (aclk),
        .i_rst_n  (aresetn),
        .i_en     (w_lfsr_en),
        .i_reload (w_lfsr_reload),
        .o_state  (w_lfsr)
    );

    // Bit 0 the LFSR will hold after this edge, so tready can stay registered
    always_comb begin
        w_lfsr_bit0_nxt = w_lfsr[0];
        if (w_lfsr_reload) begin
            w_lfsr_bit0_nxt = LFSR_SEED[0];
        end else if (w_lfsr_en) begin
            w_lfsr_bit0_nxt = ^(w_lfsr & LFSR_TAPS);
        end else begin
            w_lfsr_bit0_nxt = w_lfsr[0];
        end
    end

    assign w_tready_nxt = (w_state_nxt == ST_RUN) && w_lfsr_bit0_nxt;
`else
    assign w_tready_nxt = (w_state_nxt == ST_RUN);
`endif

    // FSM, run counters and first-mismatch capture; all outputs registered
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_tready   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_length   <= CNT_ZERO;
            r_beats    <= CNT_ZERO;
            r_errors   <= CNT_ZERO;
            r_sticky   <= 1'b0;
            r_err_exp  <= DAT_ZERO;
            r_err_got  <= DAT_ZERO;
            r_expected <= INIT;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= w_tready_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_length   <= length;
                        r_beats    <= CNT_ZERO;
                        r_errors   <= CNT_ZERO;
                        r_sticky   <= 1'b0;
                        r_err_exp  <= DAT_ZERO;
                        r_err_got  <= DAT_ZERO;
                        r_expected <= INIT;
                    end else begin
                        r_length <= r_length;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_beats    <= w_beats_inc;
                        r_expected <= r_expected + DAT_ONE;
                        if (w_mismatch) begin
                            // Saturate so a long bad run never reads back as clean
                            if (r_errors != CNT_MAX) begin
                                r_errors <= r_errors + CNT_ONE;
                            end else begin
                                r_errors <= r_errors;
                            end
                            if (!r_sticky) begin
                                r_sticky  <= 1'b1;
                                r_err_exp <= r_expected;
                                r_err_got <= s_axis_tdata;
                            end else begin
                                r_sticky <= r_sticky;
                            end
                        end else begin
                            r_errors <= r_errors;
                        end
                    end else begin
                        r_beats <= r_beats;
                    end
                end
                ST_DONE: r_beats <= r_beats;
                default: r_beats <= r_beats;
            endcase
        end
    end

    assign s_axis_tready = r_tready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign beats         = r_beats;
    assign errors        = r_errors;
    assign err_sticky    = r_sticky;
    assign err_expected  = r_err_exp;
    assign err_got       = r_err_got;

endmodule
